// File: rtl/risc_toy_pkg.sv
// Shared RISC_TOY definitions: interface widths, reset fetch address and opcode
// constants used by fetch and decode.
package risc_toy_pkg;

  localparam int unsigned AW_DEF       = 30;
  localparam int unsigned DW_DEF       = 32;
  localparam int unsigned RESET_PC_DEF = 0;

  typedef enum logic [5:0] {
    OPC_ALU  = 6'h00,
    OPC_ALUI = 6'h01,
    OPC_LD   = 6'h02,
    OPC_ST   = 6'h03,
    OPC_BR   = 6'h04,
    OPC_JAL  = 6'h05,
    OPC_JALR = 6'h06,
    OPC_LUI  = 6'h07
  } opcode_e;

  function automatic opcode_e opcode_of(input logic [DW_DEF-1:0] instr);
    return opcode_e'(instr[DW_DEF-1 -: 6]);
  endfunction

endpackage

// File: rtl/risc_toy_sync_fifo.sv
// DEPTH x W synchronous FIFO with flush and occupancy count; storage is not reset,
// only pointers and count are.
module risc_toy_sync_fifo
  import risc_toy_pkg::*;
#(
  parameter int unsigned W     = 62,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [W-1:0]                 data_i,
  output logic [W-1:0]                 data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;

  // Pointers wrap explicitly so non-power-of-two depths also work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  assign do_pop = pop_i && (cnt_q != '0);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = ptr_inc(wr_q);
      if (do_pop) rd_d = ptr_inc(rd_q);
      case ({push_i, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !do_pop && !flush_i && (32'(cnt_q) == DEPTH)));

endmodule

// File: rtl/risc_toy_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, tracks LAT cycles of in-flight
// requests and buffers returned instructions for decode.
module risc_toy_fetch_queue
  import risc_toy_pkg::*;
#(
  parameter int unsigned   AW       = AW_DEF,
  parameter int unsigned   DW       = DW_DEF,
  parameter int unsigned   DEPTH    = 4,
  parameter int unsigned   LAT      = 1,
  parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
  input  logic                        CLK,
  input  logic                        RST,
  output logic                        IREQ,
  output logic [AW-1:0]               IADDR,
  input  logic [DW-1:0]               INSTR,
  input  logic                        REDIRECT,
  input  logic [AW-1:0]               REDIRECT_PC,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  output logic [DW-1:0]               OUT_INSTR,
  output logic [AW-1:0]               OUT_PC,
  output logic [$clog2(DEPTH+1)-1:0]  OCC
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    fpc_q, fpc_d;
  logic [LAT-1:0]   vld_q, vld_d;
  logic [AW-1:0]    pc_q [LAT];
  logic [AW-1:0]    pc_d [LAT];
  logic [CW-1:0]    occ;
  logic [DW+AW-1:0] head;
  logic             ireq, push, pop;
  int unsigned      inflight;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < LAT; i++) begin
      if (vld_q[i]) inflight = inflight + 1;
    end
  end

  // Credit counts only registered state, so a same-cycle pop never frees a slot early.
  assign ireq  = !RST && !REDIRECT && ((32'(occ) + inflight) < DEPTH);
  assign IREQ  = ireq;
  assign IADDR = fpc_q;

  always_comb begin
    vld_d = vld_q;
    pc_d  = pc_q;
    fpc_d = fpc_q;
    if (REDIRECT) begin
      vld_d = '0;
      fpc_d = REDIRECT_PC;
    end else begin
      vld_d[0] = ireq;
      pc_d[0]  = fpc_q;
      for (int i = 1; i < LAT; i++) begin
        vld_d[i] = vld_q[i-1];
        pc_d[i]  = pc_q[i-1];
      end
      if (ireq) fpc_d = fpc_q + AW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_q <= '0;
      fpc_q <= RESET_PC;
    end else begin
      vld_q <= vld_d;
      fpc_q <= fpc_d;
    end
  end

  always_ff @(posedge CLK) begin
    pc_q <= pc_d;
  end

  // The last stage lines up with INSTR; a redirect drops that response too.
  assign push = vld_q[LAT-1] && !REDIRECT;
  assign pop  = OUT_VALID && OUT_READY && !REDIRECT;

  risc_toy_sync_fifo #(
    .W     (DW + AW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (REDIRECT),
    .data_i  ({INSTR, pc_q[LAT-1]}),
    .data_o  (head),
    .count_o (occ)
  );

  assign OUT_VALID = (occ != '0);
  assign OUT_INSTR = OUT_VALID ? head[DW+AW-1:AW] : '0;
  assign OUT_PC    = OUT_VALID ? head[AW-1:0] : '0;
  assign OCC       = occ;

endmodule
